// File: rtl/regfile_dump_streamer_pkg.sv
// Shared definitions for the register-file dump streamer and its register-file peers.
// State encoding, frame constants and register-file geometry live here.
package regfile_dump_streamer_pkg;

  localparam int REG_COUNT      = 32;
  localparam int REG_ADDR_W     = 5;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = WORD_W / 8;

  localparam logic [7:0] HEADER_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SEND   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5
  } dump_state_e;

  // Most-significant byte of a register word; bytes leave the block MSB first.
  function automatic logic [7:0] msb_byte(input logic [WORD_W-1:0] w);
    return w[WORD_W-1 -: 8];
  endfunction

endpackage

// File: rtl/regfile_dump_streamer_if.sv
// Register-file read port plus byte-stream valid/ready channel of the dump streamer.
// master = streamer side, slave = register file / byte sink side.
interface regfile_dump_streamer_if;
  import regfile_dump_streamer_pkg::*;

  logic [REG_ADDR_W-1:0] rd_addr;
  logic [WORD_W-1:0]     rd_data;
  logic [7:0]            byte_data;
  logic                  byte_valid;
  logic                  byte_ready;

  modport master (
    output rd_addr, byte_data, byte_valid,
    input  rd_data, byte_ready
  );

  modport slave (
    input  rd_addr, byte_data, byte_valid,
    output rd_data, byte_ready
  );

endinterface

// File: rtl/regfile_dump_streamer_serializer.sv
// word_byte_serializer: holds one captured register word and steps through its bytes MSB first.
// load captures a word, adv consumes one byte; last_byte flags the 4th byte of the word.
module word_byte_serializer
  import regfile_dump_streamer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              adv,
  input  logic [WORD_W-1:0] word,
  output logic [7:0]        nxt_byte,
  output logic              last_byte
);

  logic [WORD_W-1:0] shift;
  logic [2:0]        cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift <= '0;
      cnt   <= '0;
    end else if (load) begin
      shift <= word;
      cnt   <= '0;
    end else if (adv) begin
      shift <= {shift[WORD_W-9:0], 8'h00};
      cnt   <= cnt + 3'd1;
    end
  end

  // Byte that follows the one currently on the bus, so the owner can register it ahead.
  assign nxt_byte  = shift[WORD_W-9 -: 8];
  assign last_byte = (cnt == 3'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/regfile_dump_streamer.sv
// Debug dump of a register range as a framed byte stream: header, MSB-first words, XOR checksum.
// All bus outputs are registered; byte_valid never looks at byte_ready combinationally.
module regfile_dump_streamer
  import regfile_dump_streamer_pkg::*;
#(
  parameter int         FIRST_REG   = 0,
  parameter int         LAST_REG    = 31,
  parameter logic [7:0] HEADER_BYTE = HEADER_BYTE_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  regfile_dump_streamer_if.master bus
);

  localparam logic [REG_ADDR_W-1:0] FIRST_A = REG_ADDR_W'(FIRST_REG);
  localparam logic [REG_ADDR_W-1:0] LAST_A  = REG_ADDR_W'(LAST_REG);

  dump_state_e           state;
  logic [REG_ADDR_W-1:0] rd_addr;
  logic [7:0]            byte_data;
  logic [7:0]            checksum;
  logic                  byte_valid;
  logic                  hs;
  logic                  ser_load;
  logic                  ser_adv;
  logic [7:0]            nxt_byte;
  logic                  last_byte;

  assign hs       = byte_valid & bus.byte_ready;
  assign ser_load = (state == ST_LOAD);
  assign ser_adv  = (state == ST_SEND) & hs;

  word_byte_serializer u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (ser_load),
    .adv       (ser_adv),
    .word      (bus.rd_data),
    .nxt_byte  (nxt_byte),
    .last_byte (last_byte)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      rd_addr    <= FIRST_A;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      checksum   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_HEADER;
            checksum   <= '0;
            rd_addr    <= FIRST_A;
            byte_data  <= HEADER_BYTE;
            byte_valid <= 1'b1;
            busy       <= 1'b1;
          end
        end
        ST_HEADER: begin
          if (hs) begin
            state      <= ST_LOAD;
            byte_valid <= 1'b0;
          end
        end
        ST_LOAD: begin
          // The register is sampled here and only here; later CPU writes miss this frame.
          state      <= ST_SEND;
          byte_data  <= msb_byte(bus.rd_data);
          byte_valid <= 1'b1;
        end
        ST_SEND: begin
          if (hs) begin
            checksum <= checksum ^ byte_data;
            if (!last_byte) begin
              byte_data <= nxt_byte;
            end else if (rd_addr == LAST_A) begin
              // Checksum byte goes out back-to-back with the final data byte.
              state     <= ST_CHECK;
              byte_data <= checksum ^ byte_data;
            end else begin
              state      <= ST_LOAD;
              rd_addr    <= rd_addr + REG_ADDR_W'(1);
              byte_valid <= 1'b0;
            end
          end
        end
        ST_CHECK: begin
          if (hs) begin
            state      <= ST_DONE;
            byte_valid <= 1'b0;
            done       <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state      <= ST_IDLE;
          byte_valid <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rd_addr    = rd_addr;
  assign bus.byte_data  = byte_data;
  assign bus.byte_valid = byte_valid;

endmodule
